// File: rtl/sb_pkg.sv
// ---------------------------------------------------------------------------
// sb_pkg
// Shared sizing constants and the entry type for the store buffer.
//   SB_DEPTH    number of buffered stores (power of 2, >= 2)
//   SB_ADDR_W   CPU byte-address width
//   SB_DATA_W   data word width
//   sb_entry_t  {valid, word_addr, data} for one pending store
// ---------------------------------------------------------------------------
package sb_pkg;
    localparam int SB_DEPTH   = 4;
    localparam int SB_ADDR_W  = 32;
    localparam int SB_DATA_W  = 32;
    localparam int SB_PTR_W   = $clog2(SB_DEPTH);
    localparam int SB_WADDR_W = SB_ADDR_W - 2;

    typedef struct packed {
        logic                  valid;
        logic [SB_WADDR_W-1:0] word_addr;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
// CPU-side request/response signals and data-memory port of the store buffer.
//   master : the environment (CPU datapath + data memory)
//   slave  : the store buffer
// CPU side : cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, flush -> buffer
//            cpu_rdata, stall, busy                                -> CPU
// Mem side : mem_addr, mem_wdata, mem_memwrite, mem_memread        -> memory
//            mem_rdata (async read data)                           -> buffer
// ---------------------------------------------------------------------------
interface store_buffer_if;
    import sb_pkg::*;

    logic [SB_ADDR_W-1:0] cpu_addr;
    logic [SB_DATA_W-1:0] cpu_wdata;
    logic                 cpu_memwrite;
    logic                 cpu_memread;
    logic                 flush;
    logic [SB_DATA_W-1:0] cpu_rdata;
    logic                 stall;
    logic                 busy;
    logic [SB_ADDR_W-1:0] mem_addr;
    logic [SB_DATA_W-1:0] mem_wdata;
    logic                 mem_memwrite;
    logic                 mem_memread;
    logic [SB_DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, flush, mem_rdata,
        input  cpu_rdata, stall, busy, mem_addr, mem_wdata, mem_memwrite, mem_memread
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread, flush, mem_rdata,
        output cpu_rdata, stall, busy, mem_addr, mem_wdata, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/sb_match.sv
// ---------------------------------------------------------------------------
// sb_match
// Combinational DEPTH-way word-address compare against the pending entries.
//   entries    in   pending store entries
//   exclude    in   one-hot mask of entries to ignore (head while it drains)
//   word_addr  in   word index of the current CPU access
//   hit        out  some valid, non-excluded entry matches
//   onehot     out  one-hot index of the matching entry
// Coalescing guarantees at most one valid entry per word address.
// ---------------------------------------------------------------------------
module sb_match
    import sb_pkg::*;
(
    input  sb_entry_t             entries [SB_DEPTH],
    input  logic [SB_DEPTH-1:0]   exclude,
    input  logic [SB_WADDR_W-1:0] word_addr,
    output logic                  hit,
    output logic [SB_DEPTH-1:0]   onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            onehot[i] = entries[i].valid && !exclude[i] &&
                        (entries[i].word_addr == word_addr);
        end
    end

    assign hit = |onehot;
endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Write buffer between the CPU datapath and word-addressed data memory.
// Holds up to SB_DEPTH stores in a circular FIFO, coalesces repeat stores
// to a pending word, forwards pending data to loads in the same cycle, and
// drains lazily (memory port idle, buffer full, or flush).
//   clock  in   single clock, all state on posedge
//   reset  in   synchronous, active-high; pending stores are discarded
//   bus    slave modport of store_buffer_if (CPU side + memory port)
// ---------------------------------------------------------------------------
module store_buffer
    import sb_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam logic [SB_PTR_W:0] COUNT_FULL = (SB_PTR_W+1)'(SB_DEPTH);

    sb_entry_t             entries [SB_DEPTH];
    logic [SB_PTR_W-1:0]   head;
    logic [SB_PTR_W-1:0]   tail;
    logic [SB_PTR_W:0]     count;
    logic [SB_PTR_W:0]     count_next;
    logic                  flushing;

    logic                  stall;
    logic                  we_eff;
    logic                  re_eff;
    logic                  drain;
    logic                  enq;
    logic [SB_DEPTH-1:0]   exclude;
    logic [SB_WADDR_W-1:0] word_addr;
    logic                  hit;
    logic [SB_DEPTH-1:0]   hit_onehot;
    logic [SB_PTR_W-1:0]   hit_idx;

    assign word_addr = bus.cpu_addr[SB_ADDR_W-1:2];

    // Reset gates every memory-facing strobe so discarded stores never
    // reach memory during the reset cycle.
    assign stall  = !reset && flushing && (bus.cpu_memwrite || bus.cpu_memread);
    assign we_eff = !reset && bus.cpu_memwrite && !stall;
    // A store wins over a simultaneous load.
    assign re_eff = !reset && bus.cpu_memread && !bus.cpu_memwrite && !stall;
    assign drain  = !reset && (count != '0) && !re_eff &&
                    (flushing || (count == COUNT_FULL) || !we_eff);

    // A draining head must not absorb a coalesced store: its old data is
    // already on the memory port this cycle.
    assign exclude = drain ? ({{(SB_DEPTH-1){1'b0}}, 1'b1} << head) : '0;

    sb_match u_match (
        .entries   (entries),
        .exclude   (exclude),
        .word_addr (word_addr),
        .hit       (hit),
        .onehot    (hit_onehot)
    );

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (hit_onehot[i]) hit_idx = hit_idx | SB_PTR_W'(i);
        end
    end

    assign enq = we_eff && !hit;

    always_comb begin
        count_next = count;
        if (enq && !drain)      count_next = count + 1'b1;
        else if (!enq && drain) count_next = count - 1'b1;
    end

    assign bus.stall        = stall;
    assign bus.busy         = !reset && (count != '0);
    assign bus.mem_memwrite = drain;
    assign bus.mem_memread  = re_eff;
    assign bus.mem_addr     = drain ? {entries[head].word_addr, 2'b00} : bus.cpu_addr;
    assign bus.mem_wdata    = drain ? entries[head].data : '0;
    assign bus.cpu_rdata    = !re_eff ? '0 :
                              hit     ? entries[hit_idx].data : bus.mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flushing <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) entries[i].valid <= 1'b0;
        end else begin
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            // When full, tail == head: the enqueue below overrides the
            // valid clear of the draining head.
            if (we_eff) begin
                if (hit) begin
                    entries[hit_idx].data <= bus.cpu_wdata;
                end else begin
                    entries[tail] <= '{valid: 1'b1, word_addr: word_addr, data: bus.cpu_wdata};
                    tail          <= tail + 1'b1;
                end
            end
            count    <= count_next;
            flushing <= (flushing || (bus.flush && (count != '0))) && (count_next != '0);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import sb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];
    wr_t  exp_w;

    always #5 clock = ~clock;

    store_buffer_if bus();

    store_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Scoreboard: every memory write is popped against the expected queue.
    always @(negedge clock) begin
        if (bus.mem_memwrite === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL mem_write_unexpected: addr=%h data=%0d, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.mem_addr !== exp_w.addr || bus.mem_wdata !== exp_w.data) begin
                    fails++;
                    $display("FAIL mem_write: addr=%h data=%0d, required addr=%h data=%0d",
                             bus.mem_addr, bus.mem_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_memwrite = we;
        bus.cpu_memread  = re;
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        bus.flush        = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Bounded wait for the buffer to empty, then confirm all expected writes happened.
    task automatic drain_wait(input string name);
        for (int i = 0; i < 16 && bus.busy !== 1'b0; i++) step();
        #3;
        tests++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: busy=%b pending_expected=%0d, required busy=0 pending=0",
                     name, bus.busy, exp_q.size());
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        step();
        step();
        drive(0, 1, 32'h20, 32'h0);
        #3;
        tests++;
        if ({bus.busy, bus.stall, bus.mem_memwrite, bus.mem_memread} !== 4'b0000 ||
            bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: busy/stall/memwrite/memread=%b rdata=%h, required 0000 and 0",
                     {bus.busy, bus.stall, bus.mem_memwrite, bus.mem_memread}, bus.cpu_rdata);
        end
        step();
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_lazy_drain();
        drive(1, 0, 32'h18, 32'd111);
        push(32'h18, 32'd111);
        #3;
        tests++;
        if (bus.mem_memwrite !== 1'b0 || bus.stall !== 1'b0) begin
            fails++;
            $display("FAIL drain_store_cycle: memwrite=%b stall=%b, required 0 0", bus.mem_memwrite, bus.stall);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        #3;
        tests++;
        if (bus.busy !== 1'b1 || bus.mem_memwrite !== 1'b1 || bus.mem_addr !== 32'h18) begin
            fails++;
            $display("FAIL drain_idle_cycle: busy=%b memwrite=%b addr=%h, required 1 1 00000018",
                     bus.busy, bus.mem_memwrite, bus.mem_addr);
        end
        step();
        #3;
        tests++;
        if (bus.busy !== 1'b0 || bus.mem_memwrite !== 1'b0) begin
            fails++;
            $display("FAIL drain_after: busy=%b memwrite=%b, required 0 0", bus.busy, bus.mem_memwrite);
        end
        drain_wait("lazy_drain");
    endtask

    task automatic test_forward();
        drive(1, 0, 32'h18, 32'd5);
        push(32'h18, 32'd5);
        step();
        drive(0, 1, 32'h18, 32'h0);
        bus.mem_rdata = 32'd450;
        #3;
        tests++;
        if (bus.cpu_rdata !== 32'd5 || bus.mem_memwrite !== 1'b0 || bus.mem_memread !== 1'b1) begin
            fails++;
            $display("FAIL forward_hit: rdata=%0d memwrite=%b memread=%b, required 5 0 1",
                     bus.cpu_rdata, bus.mem_memwrite, bus.mem_memread);
        end
        step();
        drive(0, 1, 32'h1C, 32'h0);
        #3;
        tests++;
        if (bus.cpu_rdata !== 32'd450 || bus.mem_addr !== 32'h1C) begin
            fails++;
            $display("FAIL forward_miss: rdata=%0d addr=%h, required 450 0000001c", bus.cpu_rdata, bus.mem_addr);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        tests++;
        #3;
        if (bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL no_load_rdata: rdata=%h, required 0", bus.cpu_rdata);
        end
        bus.mem_rdata = '0;
        drain_wait("forward");
    endtask

    task automatic test_coalesce();
        drive(1, 0, 32'h0, 32'd1);
        step();
        drive(1, 0, 32'h0, 32'd2);
        push(32'h0, 32'd2);
        #3;
        tests++;
        if (bus.mem_memwrite !== 1'b0) begin
            fails++;
            $display("FAIL coalesce_store2: memwrite=%b, required 0", bus.mem_memwrite);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        #3;
        tests++;
        if (bus.busy !== 1'b1 || bus.mem_memwrite !== 1'b1 || bus.mem_wdata !== 32'd2) begin
            fails++;
            $display("FAIL coalesce_write: busy=%b memwrite=%b wdata=%0d, required 1 1 2",
                     bus.busy, bus.mem_memwrite, bus.mem_wdata);
        end
        step();
        #3;
        tests++;
        if (bus.busy !== 1'b0 || bus.mem_memwrite !== 1'b0) begin
            fails++;
            $display("FAIL coalesce_single: busy=%b memwrite=%b, required 0 0", bus.busy, bus.mem_memwrite);
        end
        drain_wait("coalesce");
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'(4 * i), 32'(10 + i));
            push(32'(4 * i), 32'(10 + i));
            step();
        end
        // Store to a new word while full, with a load request that must be ignored.
        drive(1, 1, 32'h10, 32'd9);
        push(32'h10, 32'd9);
        bus.mem_rdata = 32'd600;
        #3;
        tests++;
        if (bus.stall !== 1'b0 || bus.mem_memwrite !== 1'b1 || bus.mem_addr !== 32'h0 ||
            bus.mem_memread !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL full_store: stall=%b memwrite=%b addr=%h memread=%b rdata=%h, required 0 1 0 0 0",
                     bus.stall, bus.mem_memwrite, bus.mem_addr, bus.mem_memread, bus.cpu_rdata);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        for (int c = 0; c < 4; c++) begin
            #3;
            tests++;
            if (bus.busy !== 1'b1 || bus.mem_memwrite !== 1'b1) begin
                fails++;
                $display("FAIL full_count_cycle%0d: busy=%b memwrite=%b, required 1 1",
                         c, bus.busy, bus.mem_memwrite);
            end
            step();
        end
        #3;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL full_empty: busy=%b, required 0", bus.busy);
        end
        drain_wait("full");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'(4 * i), 32'(20 + i));
            push(32'(4 * i), 32'(20 + i));
            step();
        end
        drive(0, 1, 32'h0, 32'h0);
        bus.flush     = 1'b1;
        bus.mem_rdata = 32'd777;
        #3;
        tests++;
        if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'd20 || bus.mem_memwrite !== 1'b0) begin
            fails++;
            $display("FAIL flush_pulse: stall=%b rdata=%0d memwrite=%b, required 0 20 0",
                     bus.stall, bus.cpu_rdata, bus.mem_memwrite);
        end
        step();
        bus.flush = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #3;
            tests++;
            if (bus.stall !== 1'b1 || bus.mem_memwrite !== 1'b1 || bus.cpu_rdata !== 32'h0) begin
                fails++;
                $display("FAIL flush_cycle%0d: stall=%b memwrite=%b rdata=%h, required 1 1 0",
                         c, bus.stall, bus.mem_memwrite, bus.cpu_rdata);
            end
            step();
        end
        #3;
        tests++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rdata !== 32'd777) begin
            fails++;
            $display("FAIL flush_done: stall=%b busy=%b rdata=%0d, required 0 0 777",
                     bus.stall, bus.busy, bus.cpu_rdata);
        end
        step();
        // Flush on an empty buffer must not start a flush.
        drive(0, 0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        step();
        drive(0, 1, 32'h4, 32'h0);
        #3;
        tests++;
        if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'd777) begin
            fails++;
            $display("FAIL flush_empty: stall=%b rdata=%0d, required 0 777", bus.stall, bus.cpu_rdata);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        drain_wait("flush");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'(32'h40 + 4 * i), 32'(i + 1));
            step();
        end
        drive(0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        #3;
        tests++;
        if (bus.mem_memwrite !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_cycle: memwrite=%b busy=%b, required 0 0", bus.mem_memwrite, bus.busy);
        end
        step();
        reset = 1'b0;
        drive(0, 1, 32'h40, 32'h0);
        bus.mem_rdata = 32'hABCD;
        #3;
        tests++;
        if (bus.busy !== 1'b0 || bus.cpu_rdata !== 32'hABCD || bus.mem_memwrite !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_load: busy=%b rdata=%h memwrite=%b, required 0 0000abcd 0",
                     bus.busy, bus.cpu_rdata, bus.mem_memwrite);
        end
        step();
        // Reset while flushing: only the write issued before reset may appear.
        drive(1, 0, 32'h50, 32'd7);
        push(32'h50, 32'd7);
        step();
        drive(1, 0, 32'h54, 32'd8);
        step();
        drive(0, 0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        reset     = 1'b1;
        #3;
        tests++;
        if (bus.mem_memwrite !== 1'b0 || bus.stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush_cycle: memwrite=%b stall=%b, required 0 0", bus.mem_memwrite, bus.stall);
        end
        step();
        reset = 1'b0;
        drive(0, 1, 32'h54, 32'h0);
        bus.mem_rdata = 32'd55;
        #3;
        tests++;
        if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'd55 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush_after: stall=%b rdata=%0d busy=%b, required 0 55 0",
                     bus.stall, bus.cpu_rdata, bus.busy);
        end
        step();
        drive(0, 0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        drain_wait("reset_mid");
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        test_reset();
        test_lazy_drain();
        test_forward();
        test_coalesce();
        test_full();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
